acc_unit: RTL and testbench
===========================

ACC_UNIT -- requirements
Module: acc_unit

Interface
REQ-001 Parameter NOP_CODE, default 4'd15: ALUC value driven whenever no instruction executes.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-high.
REQ-004 INSTR_VALID  input  1  instruction offered this cycle.
REQ-005 INSTR_READY  output  1  unit can accept an instruction.
REQ-006 OPC  input  4  ALU operation code, same encoding as ALU ALUC.
REQ-007 OPERAND  input  16  second operand.
REQ-008 ALUC  output  4  operation code to ALU.
REQ-009 A  output  16  ALU operand A, equal to accumulator.
REQ-010 B  output  16  ALU operand B, latched OPERAND.
REQ-011 CY_IN  output  1  ALU carry input, equal to carry flag.
REQ-012 ALU_OUT  input  16  ALU result.
REQ-013 ALU_CY  input  1  ALU carry output.
REQ-014 ACC  output  16  accumulator register value.
REQ-015 CY  output  1  carry flag register value.
REQ-016 DONE  output  1  one-cycle pulse: write-back completed.

Function
REQ-017 FSM SHALL have states IDLE, EXEC, WB; only IDLE asserts INSTR_READY.
REQ-018 IDLE: on INSTR_VALID=1, the rising edge SHALL latch OPC and OPERAND and enter EXEC; otherwise remain IDLE.
REQ-019 EXEC: ALUC SHALL equal latched OPC, B latched OPERAND; the EXEC-ending edge SHALL perform write-back and enter WB.
REQ-020 WB: DONE SHALL be 1 for exactly this cycle; next edge SHALL return to IDLE.
REQ-021 Outside EXEC, ALUC SHALL equal NOP_CODE.
REQ-022 Latency: accept edge to DONE high = 2 cycles; max throughput one instruction per 3 cycles.
REQ-023 INSTR_VALID in EXEC or WB SHALL be ignored; no queuing.
REQ-024 Write-back for OPC 0-3, 6-10, 13, 14: ACC <= ALU_OUT; CY unchanged.
REQ-025 Write-back for OPC 4, 5: ACC <= ALU_OUT and CY <= ALU_CY.
REQ-026 Write-back for OPC 11, 12: CY <= ALU_CY; ACC unchanged.
REQ-027 Write-back for OPC 15: ACC and CY unchanged; DONE still pulses.
REQ-028 A and CY_IN SHALL be driven directly from ACC and CY registers (no extra delay).
REQ-029 Arithmetic is performed only by the ALU; the unit SHALL not modify ALU_OUT; 16-bit wrap-around is accepted as delivered.

Reset
REQ-030 RST=1 SHALL immediately force: state IDLE, ACC=0, CY=0, latched OPC=NOP_CODE, latched OPERAND=0, DONE=0, ALUC=NOP_CODE, INSTR_READY=1.
REQ-031 RST asserted during EXEC or WB SHALL abort the instruction with no write-back and no DONE pulse.
REQ-032 INSTR_VALID coincident with the first edge after RST release SHALL be accepted.

Configuration
REQ-033 Macro ACC_UNIT_ZERO_FLAG_EN: when defined, output ZF (1 bit) SHALL exist, registered, updated at every write-back that modifies ACC to (new ACC == 0), reset to 1.
REQ-034 Without ACC_UNIT_ZERO_FLAG_EN, port ZF and its register SHALL not exist; all other behaviour identical.

Verification
REQ-035 Reset then OPC=1, OPERAND=16'h1234 -> DONE 2 cycles after accept, ACC=16'h1234, CY=0.
REQ-036 ACC=16'hFFFF, OPC=4, OPERAND=16'h0001 -> ACC=16'h0000, CY=1; with macro ZF=1.
REQ-037 CY=1, ACC=16'h0001, OPC=5, OPERAND=16'h0001 -> ACC=16'h0003, CY=0.
REQ-038 OPC=12 then OPC=11 -> CY 1 then 0, ACC unchanged; OPC=15 -> DONE pulses, ACC/CY unchanged.
REQ-039 INSTR_VALID held high continuously with distinct OPERANDs -> exactly one accept per 3 cycles, INSTR_READY low in EXEC/WB, ALUC=15 outside EXEC.
REQ-040 RST pulsed mid-EXEC of OPC=9 -> ACC=0, CY=0, no DONE, state IDLE.

Source files
------------

// File: rtl/acc_unit.sv
// acc_unit: accumulator sequencer for an external ALU (IDLE -> EXEC -> WB).
// Ports: CLK, RST, INSTR_VALID/READY, OPC, OPERAND, ALUC, A, B, CY_IN,
//   ALU_OUT, ALU_CY, ACC, CY, DONE; ZF when ACC_UNIT_ZERO_FLAG_EN is defined.
module acc_unit #(
  parameter logic [3:0] NOP_CODE = 4'd15
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        INSTR_VALID,
  output logic        INSTR_READY,
  input  logic [3:0]  OPC,
  input  logic [15:0] OPERAND,
  output logic [3:0]  ALUC,
  output logic [15:0] A,
  output logic [15:0] B,
  output logic        CY_IN,
  input  logic [15:0] ALU_OUT,
  input  logic        ALU_CY,
  output logic [15:0] ACC,
  output logic        CY,
  output logic        DONE
`ifdef ACC_UNIT_ZERO_FLAG_EN
  ,
  output logic        ZF
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    WB
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  opc_q, opc_d;
  logic [15:0] opd_q, opd_d;
  logic [15:0] acc_q, acc_d;
  logic        cy_q, cy_d;
  logic        wr_acc, wr_cy;

  // Which registers the latched opcode writes back.
  always_comb begin
    wr_acc = 1'b1;
    wr_cy  = 1'b0;
    unique case (opc_q)
      4'd4, 4'd5: begin
        wr_acc = 1'b1;
        wr_cy  = 1'b1;
      end
      4'd11, 4'd12: begin
        wr_acc = 1'b0;
        wr_cy  = 1'b1;
      end
      4'd15: begin
        wr_acc = 1'b0;
        wr_cy  = 1'b0;
      end
      default: begin
        wr_acc = 1'b1;
        wr_cy  = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    opc_d       = opc_q;
    opd_d       = opd_q;
    acc_d       = acc_q;
    cy_d        = cy_q;
    INSTR_READY = 1'b0;
    DONE        = 1'b0;
    ALUC        = NOP_CODE;
    unique case (state_q)
      IDLE: begin
        INSTR_READY = 1'b1;
        if (INSTR_VALID) begin
          opc_d   = OPC;
          opd_d   = OPERAND;
          state_d = EXEC;
        end
      end
      EXEC: begin
        ALUC    = opc_q;
        state_d = WB;
        if (wr_acc) acc_d = ALU_OUT;
        if (wr_cy)  cy_d  = ALU_CY;
      end
      WB: begin
        DONE    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      opc_q   <= NOP_CODE;
      opd_q   <= 16'h0000;
      acc_q   <= 16'h0000;
      cy_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      opd_q   <= opd_d;
      acc_q   <= acc_d;
      cy_q    <= cy_d;
    end
  end

`ifdef ACC_UNIT_ZERO_FLAG_EN
  logic zf_q, zf_d;

  // Tracks the ACC value written, so it only moves with ACC.
  always_comb begin
    zf_d = zf_q;
    if (state_q == EXEC && wr_acc)
      zf_d = (ALU_OUT == 16'h0000);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) zf_q <= 1'b1;
    else     zf_q <= zf_d;
  end

  assign ZF = zf_q;
`endif

  assign A     = acc_q;
  assign B     = opd_q;
  assign CY_IN = cy_q;
  assign ACC   = acc_q;
  assign CY    = cy_q;

endmodule

// File: tb/tb_acc_unit.sv
// tb_acc_unit: randomized scoreboard bench for acc_unit.
// Includes a behavioural ALU and an architectural accumulator model.
`timescale 1ns/1ps
module tb_acc_unit;

  localparam logic [3:0] NOP = 4'd15;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        INSTR_VALID = 1'b0;
  logic        INSTR_READY;
  logic [3:0]  OPC = 4'd0;
  logic [15:0] OPERAND = 16'h0;
  logic [3:0]  ALUC;
  logic [15:0] A, B, ALU_OUT, ACC;
  logic        CY_IN, ALU_CY, CY, DONE;
`ifdef ACC_UNIT_ZERO_FLAG_EN
  logic        ZF;
`endif

  acc_unit #(.NOP_CODE(NOP)) dut (
    .CLK(CLK), .RST(RST),
    .INSTR_VALID(INSTR_VALID), .INSTR_READY(INSTR_READY),
    .OPC(OPC), .OPERAND(OPERAND),
    .ALUC(ALUC), .A(A), .B(B), .CY_IN(CY_IN),
    .ALU_OUT(ALU_OUT), .ALU_CY(ALU_CY),
    .ACC(ACC), .CY(CY), .DONE(DONE)
`ifdef ACC_UNIT_ZERO_FLAG_EN
    , .ZF(ZF)
`endif
  );

  always #5 CLK = ~CLK;

  // Bench-chosen ALU: returns {carry, result}.
  function automatic logic [16:0] alu(input logic [3:0] op,
    input logic [15:0] a, input logic [15:0] b, input logic ci);
    case (op)
      4'd0:  alu = {1'b0, a & b};
      4'd1:  alu = {1'b0, a | b};
      4'd2:  alu = {1'b0, a ^ b};
      4'd3:  alu = {1'b0, ~a};
      4'd4:  alu = {1'b0, a} + {1'b0, b};
      4'd5:  alu = {1'b0, a} + {1'b0, b} + {16'h0, ci};
      4'd6:  alu = {1'b0, a} - {1'b0, b};
      4'd7:  alu = {a[15], a[14:0], 1'b0};
      4'd8:  alu = {a[0], 1'b0, a[15:1]};
      4'd9:  alu = {1'b0, b};
      4'd10: alu = {1'b0, a} + 17'd1;
      4'd11: alu = {1'b0, a};
      4'd12: alu = {1'b1, a};
      4'd13: alu = {a[15], a[14:0], a[15]};
      4'd14: alu = {1'b0, b};
      default: alu = {ci, a};
    endcase
  endfunction

  always_comb {ALU_CY, ALU_OUT} = alu(ALUC, A, B, CY_IN);

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [15:0] acc;
    logic        cy;
    logic        zf;
    int          due;
  } exp_t;

  exp_t        sbq[$];
  int          ph = 0;
  int          cyc = 0;
  int          ndone = 0;
  logic [3:0]  lopc = NOP;
  logic [15:0] lopd = 16'h0;
  logic [15:0] macc = 16'h0;
  logic        mcy = 1'b0;
  logic        mzf = 1'b1;
  exp_t        pend;

  // Architectural model: instruction takes effect one edge after accept.
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      ph = 0; macc = 16'h0; mcy = 1'b0; mzf = 1'b1;
      lopc = NOP; lopd = 16'h0;
      sbq.delete();
    end else begin
      cyc++;
      case (ph)
        0: if (INSTR_VALID) begin
          logic [16:0] r;
          r = alu(OPC, macc, OPERAND, mcy);
          lopc = OPC; lopd = OPERAND;
          pend.acc = macc; pend.cy = mcy; pend.zf = mzf;
          if (OPC == 4 || OPC == 5) begin
            pend.acc = r[15:0]; pend.cy = r[16];
          end else if (OPC == 11 || OPC == 12) begin
            pend.cy = r[16];
          end else if (OPC != 15) begin
            pend.acc = r[15:0];
          end
          if (!(OPC == 11 || OPC == 12 || OPC == 15))
            pend.zf = (pend.acc == 16'h0);
          pend.due = cyc + 1;
          sbq.push_back(pend);
          ph = 1;
        end
        1: begin
          macc = pend.acc; mcy = pend.cy; mzf = pend.zf; ph = 2;
        end
        default: ph = 0;
      endcase
    end
  end

  // Monitor: per-cycle interface checks and DONE-driven scoreboard.
  always @(negedge CLK) begin
    if (!RST) begin
      chk("ready", INSTR_READY, ph == 0);
      chk("aluc", ALUC, (ph == 1) ? lopc : NOP);
      chk("a", A, macc);
      chk("cy_in", CY_IN, mcy);
      chk("acc", ACC, macc);
      chk("done", DONE, ph == 2);
      if (ph == 1) chk("b", B, lopd);
      if (DONE) begin
        ndone++;
        if (sbq.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("sb_acc", ACC, e.acc);
          chk("sb_cy", CY, e.cy);
          chk("sb_latency", cyc, e.due);
`ifdef ACC_UNIT_ZERO_FLAG_EN
          chk("sb_zf", ZF, e.zf);
`endif
        end
      end else if (sbq.size() > 0 && cyc > sbq[0].due) begin
        chk("missing_done", cyc, sbq[0].due);
        void'(sbq.pop_front());
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [15:0] d);
    int n;
    n = 0;
    @(negedge CLK);
    while (ph != 0 && n < 10) begin
      @(negedge CLK);
      n++;
    end
    chk("issue_wait", ph, 0);
    INSTR_VALID = 1'b1; OPC = op; OPERAND = d;
    @(negedge CLK);
    INSTR_VALID = 1'b0;
  endtask

  // Returns in the WB cycle of the instruction.
  task automatic run(input logic [3:0] op, input logic [15:0] d);
    issue(op, d);
    @(negedge CLK);
    #1;
  endtask

  initial begin
    int d0;
    int n;
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_acc", ACC, 16'h0);
    chk("rst_cy", CY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_aluc", ALUC, NOP);
    chk("rst_ready", INSTR_READY, 1);
    chk("rst_b", B, 16'h0);
`ifdef ACC_UNIT_ZERO_FLAG_EN
    chk("rst_zf", ZF, 1);
`endif
    // Valid coincident with the first edge after release.
    @(negedge CLK);
    RST = 1'b0;
    INSTR_VALID = 1'b1; OPC = 4'd1; OPERAND = 16'h1234;
    @(negedge CLK);
    INSTR_VALID = 1'b0;
    @(negedge CLK);
    #1;
    chk("load_acc", ACC, 16'h1234);
    chk("load_cy", CY, 0);
    chk("load_done", DONE, 1);

    run(4'd14, 16'hFFFF);
    run(4'd4, 16'h0001);
    chk("add_wrap_acc", ACC, 16'h0000);
    chk("add_wrap_cy", CY, 1);
`ifdef ACC_UNIT_ZERO_FLAG_EN
    chk("add_wrap_zf", ZF, 1);
`endif
    run(4'd14, 16'h0001);
    run(4'd5, 16'h0001);
    chk("adc_acc", ACC, 16'h0003);
    chk("adc_cy", CY, 0);
    run(4'd12, 16'h0);
    chk("sec_cy", CY, 1);
    chk("sec_acc", ACC, 16'h0003);
    run(4'd11, 16'h0);
    chk("clc_cy", CY, 0);
    chk("clc_acc", ACC, 16'h0003);
    run(4'd15, 16'hAAAA);
    chk("nop_done", DONE, 1);
    chk("nop_acc", ACC, 16'h0003);
    chk("nop_cy", CY, 0);

    // Valid held high: one accept every third cycle.
    @(negedge CLK);
    d0 = ndone;
    INSTR_VALID = 1'b1;
    for (int i = 0; i < 15; i++) begin
      OPC = 4'($urandom);
      OPERAND = 16'(i * 257 + 1);
      @(negedge CLK);
    end
    INSTR_VALID = 1'b0;
    repeat (3) @(negedge CLK);
    chk("stream_accepts", ndone - d0, 5);

    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge CLK);
      issue(4'($urandom), 16'($urandom));
    end

    // Reset during EXEC aborts the instruction.
    run(4'd14, 16'h5A5A);
    issue(4'd9, 16'hBEEF);
    RST = 1'b1;
    #1;
    chk("abort_acc", ACC, 16'h0);
    chk("abort_cy", CY, 0);
    chk("abort_done", DONE, 0);
    chk("abort_ready", INSTR_READY, 1);
    chk("abort_aluc", ALUC, NOP);
    @(negedge CLK);
    RST = 1'b0;
    repeat (4) @(negedge CLK);
    chk("abort_idle_acc", ACC, 16'h0);

    n = 0;
    while (sbq.size() > 0 && n < 10) begin
      @(negedge CLK);
      n++;
    end
    chk("drain", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
